// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the I/D memory bus arbiter
package mem_arb_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [3:0]  wrstb_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_I_XFER,
        ARB_D_XFER
    } arb_state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_e;

    // Returned to the owner when a bus cycle is abandoned by the watchdog
    localparam u32_t ARB_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - core fetch/data ports and memory bus bundle for mem_arb
interface mem_arb_if;
    import mem_arb_pkg::*;

    // fetch port
    logic   i_req;
    u32_t   i_addr;
    logic   i_rdy;
    u32_t   i_rddata;

    // data port
    logic   d_req;
    u32_t   d_addr;
    u32_t   d_wrdata;
    wrstb_t d_wrstb;
    logic   d_rdy;
    u32_t   d_rddata;

    // memory bus
    logic   bus_req;
    u32_t   bus_addr;
    u32_t   bus_wrdata;
    wrstb_t bus_wrstb;
    logic   bus_ack;
    u32_t   bus_rddata;
    logic   bus_err;

    // arbiter side
    modport master (
        input  i_req, i_addr, d_req, d_addr, d_wrdata, d_wrstb, bus_ack, bus_rddata,
        output i_rdy, i_rddata, d_rdy, d_rddata,
        output bus_req, bus_addr, bus_wrdata, bus_wrstb, bus_err
    );

    // core and memory side
    modport slave (
        output i_req, i_addr, d_req, d_addr, d_wrdata, d_wrstb, bus_ack, bus_rddata,
        input  i_rdy, i_rddata, d_rdy, d_rddata,
        input  bus_req, bus_addr, bus_wrdata, bus_wrstb, bus_err
    );

endinterface

// File: rtl/mem_arb_wdog.sv
// rtl/mem_arb_wdog.sv - 8-bit bus cycle watchdog with clear/enable and expire flag
module mem_arb_wdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] r_count;

    // count stalled bus cycles; parks at the limit until the next clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_expire) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expire = (r_count == LIMIT);

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - fetch/data arbiter onto one single-port memory bus
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_arb_if.master  arb
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_e           r_state;
    arb_state_e           w_state_nx;
    arb_owner_e           w_owner;
    logic [STREAK_W-1:0]  r_streak;
    logic                 r_i_rdy;
    logic                 r_d_rdy;
    u32_t                 r_i_rddata;
    u32_t                 r_d_rddata;
    u32_t                 r_bus_addr;
    u32_t                 r_bus_wrdata;
    wrstb_t               r_bus_wrstb;
    logic                 r_bus_err;
    logic                 w_grant_i;
    logic                 w_grant_d;
    logic                 w_done;
    logic                 w_abort;
    logic                 w_expire;
    logic                 w_xfer;
    u32_t                 w_fin_data;

    assign w_xfer  = (r_state != ARB_IDLE);
    assign w_owner = (r_state == ARB_D_XFER) ? OWN_D : OWN_I;

    mem_arb_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_grant_i | w_grant_d),
        .i_en     (w_xfer & ~arb.bus_ack),
        .o_expire (w_expire)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // grant selection and transfer completion
    always_comb begin
        w_state_nx = r_state;
        w_grant_i  = 1'b0;
        w_grant_d  = 1'b0;
        w_done     = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                // While a rdy pulse is out, the completing port's req is stale;
                // holding off both ports here also spaces accesses 3 cycles apart.
                if (!r_i_rdy && !r_d_rdy) begin
                    if (arb.d_req && (!arb.i_req || (r_streak < STREAK_MAX))) begin
                        w_grant_d  = 1'b1;
                        w_state_nx = ARB_D_XFER;
                    end else if (arb.i_req) begin
                        w_grant_i  = 1'b1;
                        w_state_nx = ARB_I_XFER;
                    end
                end
            end
            ARB_I_XFER, ARB_D_XFER: begin
                // a late ack in the expiry cycle still completes normally
                if (arb.bus_ack) begin
                    w_done     = 1'b1;
                    w_state_nx = ARB_IDLE;
                end else if (w_expire) begin
                    w_abort    = 1'b1;
                    w_state_nx = ARB_IDLE;
                end
            end
            default: begin
                w_state_nx = ARB_IDLE;
            end
        endcase
    end

    assign w_fin_data = w_done ? arb.bus_rddata : ARB_ABORT_DATA;

    // bus latches, owner read data, rdy pulses and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bus_addr   <= '0;
            r_bus_wrdata <= '0;
            r_bus_wrstb  <= '0;
            r_i_rdy      <= 1'b0;
            r_d_rdy      <= 1'b0;
            r_i_rddata   <= '0;
            r_d_rddata   <= '0;
            r_bus_err    <= 1'b0;
        end else begin
            r_i_rdy <= 1'b0;
            r_d_rdy <= 1'b0;
            if (w_grant_i) begin
                r_bus_addr   <= arb.i_addr;
                r_bus_wrdata <= '0;
                r_bus_wrstb  <= '0;
            end
            if (w_grant_d) begin
                r_bus_addr   <= arb.d_addr;
                r_bus_wrdata <= arb.d_wrdata;
                r_bus_wrstb  <= arb.d_wrstb;
            end
            if (w_done || w_abort) begin
                if (w_owner == OWN_I) begin
                    r_i_rdy    <= 1'b1;
                    r_i_rddata <= w_fin_data;
                end else begin
                    r_d_rdy    <= 1'b1;
                    r_d_rddata <= w_fin_data;
                end
            end
            if (w_abort) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // consecutive D grants made while a fetch was waiting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_streak <= '0;
        end else if (w_grant_i) begin
            r_streak <= '0;
        end else if (w_grant_d) begin
            if (!arb.i_req) begin
                r_streak <= '0;
            end else if (r_streak < STREAK_MAX) begin
                r_streak <= r_streak + STREAK_W'(1);
            end
        end
    end

    assign arb.bus_req    = w_xfer;
    assign arb.bus_addr   = r_bus_addr;
    assign arb.bus_wrdata = r_bus_wrdata;
    assign arb.bus_wrstb  = r_bus_wrstb;
    assign arb.bus_err    = r_bus_err;
    assign arb.i_rdy      = r_i_rdy;
    assign arb.i_rddata   = r_i_rddata;
    assign arb.d_rdy      = r_d_rdy;
    assign arb.d_rddata   = r_d_rddata;

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed self-checking bench for mem_arb
module tb_mem_arb;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_arb_if u_if ();

    mem_arb #(
        .MAX_D_STREAK (4),
        .TIMEOUT_CYC  (8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (u_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // requester protocol: req and payload held until the rdy pulse
    logic   p_rst = 1'b0;
    logic   p_i_req = 1'b0, p_i_rdy = 1'b0, p_d_req = 1'b0, p_d_rdy = 1'b0;
    u32_t   p_i_addr = '0, p_d_addr = '0, p_d_wrdata = '0;
    wrstb_t p_d_wrstb = '0;
    always @(negedge clk) begin
        if (p_rst && p_i_req && !p_i_rdy && (u_if.i_req !== 1'b1 || u_if.i_addr !== p_i_addr)) begin
            errors++;
            $display("FAIL i_hold req=%0b addr=%h want req=1 addr=%h", u_if.i_req, u_if.i_addr, p_i_addr);
        end
        if (p_rst && p_d_req && !p_d_rdy && (u_if.d_req !== 1'b1 || u_if.d_addr !== p_d_addr ||
            u_if.d_wrdata !== p_d_wrdata || u_if.d_wrstb !== p_d_wrstb)) begin
            errors++;
            $display("FAIL d_hold req=%0b addr=%h want req=1 addr=%h", u_if.d_req, u_if.d_addr, p_d_addr);
        end
        p_rst      <= rst_n;
        p_i_req    <= u_if.i_req;
        p_i_rdy    <= u_if.i_rdy;
        p_i_addr   <= u_if.i_addr;
        p_d_req    <= u_if.d_req;
        p_d_rdy    <= u_if.d_rdy;
        p_d_addr   <= u_if.d_addr;
        p_d_wrdata <= u_if.d_wrdata;
        p_d_wrstb  <= u_if.d_wrstb;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        u_if.i_req = 0; u_if.i_addr = '0; u_if.d_req = 0; u_if.d_addr = '0;
        u_if.d_wrdata = '0; u_if.d_wrstb = '0; u_if.bus_ack = 0; u_if.bus_rddata = '0;
        step(); step();
        checks++;
        if ({u_if.bus_req, u_if.i_rdy, u_if.d_rdy, u_if.bus_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b want 0000", {u_if.bus_req, u_if.i_rdy, u_if.d_rdy, u_if.bus_err});
        end
        checks++;
        if ({u_if.bus_addr, u_if.bus_wrdata, u_if.bus_wrstb, u_if.i_rddata, u_if.d_rddata} !== '0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h %h want all 0", u_if.bus_addr, u_if.bus_wrdata,
                               u_if.bus_wrstb, u_if.i_rddata, u_if.d_rddata);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_fetch();
        step(); u_if.i_req = 1; u_if.i_addr = 32'h100;                 // cycle 0
        checks++;
        if (u_if.bus_req !== 1'b0) begin errors++; $display("FAIL fetch_c0_bus_req got %b want 0", u_if.bus_req); end
        step();                                                        // cycle 1
        checks++;
        if ({u_if.bus_req, u_if.bus_addr, u_if.bus_wrdata, u_if.bus_wrstb} !== {1'b1, 32'h100, 32'h0, 4'h0}) begin
            errors++; $display("FAIL fetch_bus got %b %h %h %h want 1 100 0 0", u_if.bus_req, u_if.bus_addr, u_if.bus_wrdata, u_if.bus_wrstb);
        end
        u_if.bus_ack = 1; u_if.bus_rddata = 32'h1234_5678;
        step();                                                        // cycle 2
        u_if.bus_ack = 0; u_if.bus_rddata = '0;
        checks++;
        if ({u_if.i_rdy, u_if.d_rdy, u_if.bus_req} !== 3'b100) begin
            errors++; $display("FAIL fetch_rdy got %b want 100", {u_if.i_rdy, u_if.d_rdy, u_if.bus_req});
        end
        checks++;
        if (u_if.i_rddata !== 32'h1234_5678) begin errors++; $display("FAIL fetch_data got %h want 12345678", u_if.i_rddata); end
        step(); u_if.i_req = 0;                                        // cycle 3
        checks++;
        if (u_if.i_rdy !== 1'b0) begin errors++; $display("FAIL fetch_pulse got %b want 0", u_if.i_rdy); end
    endtask

    task automatic test_contention();
        step();                                                        // cycle 0
        u_if.i_req = 1; u_if.i_addr = 32'h300; u_if.d_req = 1; u_if.d_addr = 32'h200;
        step();                                                        // cycle 1
        checks++;
        if ({u_if.bus_req, u_if.bus_addr} !== {1'b1, 32'h200}) begin
            errors++; $display("FAIL cont_d_first got %b %h want 1 200", u_if.bus_req, u_if.bus_addr);
        end
        u_if.bus_ack = 1; u_if.bus_rddata = 32'h0D0D_0D0D;
        step(); u_if.bus_ack = 0;                                      // cycle 2
        checks++;
        if ({u_if.i_rdy, u_if.d_rdy, u_if.bus_req} !== 3'b010 || u_if.d_rddata !== 32'h0D0D_0D0D) begin
            errors++; $display("FAIL cont_d_rdy got %b %h want 010 0d0d0d0d", {u_if.i_rdy, u_if.d_rdy, u_if.bus_req}, u_if.d_rddata);
        end
        step(); u_if.d_req = 0;                                        // cycle 3
        checks++;
        if (u_if.bus_req !== 1'b0) begin errors++; $display("FAIL cont_gap got %b want 0", u_if.bus_req); end
        step();                                                        // cycle 4
        checks++;
        if ({u_if.bus_req, u_if.bus_addr} !== {1'b1, 32'h300}) begin
            errors++; $display("FAIL cont_i_second got %b %h want 1 300", u_if.bus_req, u_if.bus_addr);
        end
        u_if.bus_ack = 1; u_if.bus_rddata = 32'h1111_2222;
        step(); u_if.bus_ack = 0;                                      // cycle 5
        checks++;
        if ({u_if.i_rdy, u_if.d_rdy} !== 2'b10 || u_if.i_rddata !== 32'h1111_2222) begin
            errors++; $display("FAIL cont_i_rdy got %b %h want 10 11112222", {u_if.i_rdy, u_if.d_rdy}, u_if.i_rddata);
        end
        step(); u_if.i_req = 0;                                        // cycle 6
    endtask

    task automatic test_starvation();
        logic gseq [6];
        int   ngr = 0;
        logic prev_bus = 0, drop_d = 0, drop_i = 0;
        for (int k = 0; k < 6; k++) gseq[k] = 1'b0;
        step(); u_if.i_req = 1; u_if.i_addr = 32'h500; u_if.d_req = 1; u_if.d_addr = 32'h400;
        for (int c = 0; c < 80 && (u_if.i_req || u_if.d_req || u_if.bus_req); c++) begin
            step();
            if (drop_d) u_if.d_req = 0;
            if (drop_i) u_if.i_req = 0;
            drop_d = 0; drop_i = 0;
            if (u_if.d_rdy && ngr >= 6) drop_d = 1;
            if (u_if.i_rdy && ngr >= 6) drop_i = 1;
            if (u_if.bus_req && !prev_bus) begin
                if (ngr < 6) gseq[ngr] = (u_if.bus_addr == 32'h400);
                ngr++;
            end
            prev_bus = u_if.bus_req;
            u_if.bus_ack = u_if.bus_req;
        end
        u_if.bus_ack = 0;
        checks++;
        if (ngr != 7 || u_if.i_req || u_if.d_req) begin
            errors++; $display("FAIL starve_grants got %0d want 7 (drained=%0b)", ngr, !(u_if.i_req || u_if.d_req));
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (gseq[k] !== (k != 4)) begin
                errors++; $display("FAIL starve_seq%0d got d=%b want d=%b", k, gseq[k], (k != 4));
            end
        end
        step();
    endtask

    task automatic test_store();
        step(); u_if.d_req = 1; u_if.d_addr = 32'h40; u_if.d_wrdata = 32'hAABB_CCDD; u_if.d_wrstb = 4'b0011;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if ({u_if.bus_req, u_if.bus_addr, u_if.bus_wrdata, u_if.bus_wrstb, u_if.d_rdy} !==
                {1'b1, 32'h40, 32'hAABB_CCDD, 4'b0011, 1'b0}) begin
                errors++; $display("FAIL store_hold%0d got %b %h %h %b rdy=%b want 1 40 aabbccdd 0011 rdy=0", k,
                                   u_if.bus_req, u_if.bus_addr, u_if.bus_wrdata, u_if.bus_wrstb, u_if.d_rdy);
            end
        end
        u_if.bus_ack = 1; u_if.bus_rddata = 32'h5566_7788;
        step(); u_if.bus_ack = 0;
        checks++;
        if ({u_if.d_rdy, u_if.bus_req} !== 2'b10 || u_if.d_rddata !== 32'h5566_7788) begin
            errors++; $display("FAIL store_rdy got %b %h want 10 55667788", {u_if.d_rdy, u_if.bus_req}, u_if.d_rddata);
        end
        step(); u_if.d_req = 0; u_if.d_wrstb = '0; u_if.d_wrdata = '0;
        checks++;
        if (u_if.d_rdy !== 1'b0) begin errors++; $display("FAIL store_pulse got %b want 0", u_if.d_rdy); end
    endtask

    task automatic test_timeout();
        step();                                                        // cycle 0
        checks++;
        if (u_if.bus_err !== 1'b0) begin errors++; $display("FAIL to_err_pre got %b want 0", u_if.bus_err); end
        u_if.d_req = 1; u_if.d_addr = 32'h80;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if ({u_if.bus_req, u_if.d_rdy} !== 2'b10) begin
                errors++; $display("FAIL to_wait%0d got %b want 10", k, {u_if.bus_req, u_if.d_rdy});
            end
        end
        step();                                                        // cycle 9
        checks++;
        if ({u_if.d_rdy, u_if.bus_req, u_if.bus_err} !== 3'b101 || u_if.d_rddata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL to_abort got %b %h want 101 deadbeef", {u_if.d_rdy, u_if.bus_req, u_if.bus_err}, u_if.d_rddata);
        end
        step(); u_if.d_req = 0; u_if.i_req = 1; u_if.i_addr = 32'h104;  // cycle 10
        step();                                                        // cycle 11
        u_if.bus_ack = 1; u_if.bus_rddata = 32'hCAFE_0001;
        step(); u_if.bus_ack = 0;                                      // cycle 12
        checks++;
        if ({u_if.i_rdy, u_if.bus_err} !== 2'b11 || u_if.i_rddata !== 32'hCAFE_0001) begin
            errors++; $display("FAIL to_sticky got %b %h want 11 cafe0001", {u_if.i_rdy, u_if.bus_err}, u_if.i_rddata);
        end
        step(); u_if.i_req = 0;
    endtask

    task automatic test_reset_mid_xfer();
        step(); u_if.i_req = 1; u_if.i_addr = 32'h600;                 // cycle 0
        step();                                                        // cycle 1
        step(); rst_n = 1'b0;                                          // cycle 2
        checks++;
        if (u_if.bus_req !== 1'b1) begin errors++; $display("FAIL rstx_active got %b want 1", u_if.bus_req); end
        step();                                                        // cycle 3
        checks++;
        if ({u_if.bus_req, u_if.bus_err, u_if.i_rdy} !== 3'b000) begin
            errors++; $display("FAIL rstx_abandon got %b want 000", {u_if.bus_req, u_if.bus_err, u_if.i_rdy});
        end
        rst_n = 1'b1; u_if.i_req = 0;
        step();                                                        // cycle 4
        checks++;
        if ({u_if.bus_req, u_if.i_rdy} !== 2'b00) begin
            errors++; $display("FAIL rstx_quiet got %b want 00", {u_if.bus_req, u_if.i_rdy});
        end
        step(); u_if.i_req = 1; u_if.i_addr = 32'h700;                 // cycle 5
        step();                                                        // cycle 6
        checks++;
        if ({u_if.bus_req, u_if.bus_addr} !== {1'b1, 32'h700}) begin
            errors++; $display("FAIL rstx_new got %b %h want 1 700", u_if.bus_req, u_if.bus_addr);
        end
        u_if.bus_ack = 1; u_if.bus_rddata = 32'h7777_0000;
        step(); u_if.bus_ack = 0;                                      // cycle 7
        checks++;
        if (u_if.i_rdy !== 1'b1 || u_if.i_rddata !== 32'h7777_0000) begin
            errors++; $display("FAIL rstx_done got %b %h want 1 77770000", u_if.i_rdy, u_if.i_rddata);
        end
        step(); u_if.i_req = 0;
    endtask

    task automatic test_ack_wins_abort();
        step(); u_if.d_req = 1; u_if.d_addr = 32'h88;                  // cycle 0
        for (int k = 1; k <= 8; k++) step();                           // cycle 8: expiry cycle
        u_if.bus_ack = 1; u_if.bus_rddata = 32'h0BAD_F00D;
        step(); u_if.bus_ack = 0;                                      // cycle 9
        checks++;
        if ({u_if.d_rdy, u_if.i_rdy, u_if.bus_err} !== 3'b100 || u_if.d_rddata !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL ackwin got %b %h want 100 0badf00d", {u_if.d_rdy, u_if.i_rdy, u_if.bus_err}, u_if.d_rddata);
        end
        step(); u_if.d_req = 0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_store();
        test_timeout();
        test_reset_mid_xfer();
        test_ack_wins_abort();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached at %0t", $time);
        $fatal(1);
    end

endmodule
